// File: rtl/seven_segment_counter_display_if.sv
// Bus bundle between the video timing side and the seven-segment counter renderer.
// The master drives position, control and counter pulses; the slave returns count, overflow and pixel colour.
interface seven_segment_counter_display_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   localparam int unsigned COUNT_W = 4 * NUM_DIGITS;

   logic               display_on;
   logic [8:0]         hpos;
   logic [8:0]         vpos;
   logic               inc;
   logic               clr;
   logic               blank_lz;
   logic               blink_en;
   logic [COUNT_W-1:0] count;
   logic               overflow;
   logic [2:0]         rgb;

   modport master (
      output display_on, hpos, vpos, inc, clr, blank_lz, blink_en,
      input  count, overflow, rgb
   );

   modport slave (
      input  display_on, hpos, vpos, inc, clr, blank_lz, blink_en,
      output count, overflow, rgb
   );
endinterface

// File: rtl/seven_segment_counter_display.sv
// Multi-digit BCD/hex event counter rendered as scaled 5x5 seven-segment glyphs.
// The live count is latched into a shadow at frame start so a frame never shows a half-updated value.
module seven_segment_counter_display #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned X0           = 64,
   parameter int unsigned Y0           = 64,
   parameter int unsigned SCALE_LOG2   = 1,
   parameter int unsigned HEX_MODE     = 0,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter logic [2:0]  FG           = 3'b010
) (
   input  logic                          clk,
   input  logic                          reset,
   seven_segment_counter_display_if.slave bus
);
   localparam int unsigned COUNT_W   = 4 * NUM_DIGITS;
   localparam int unsigned FRAME_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [3:0]  DIGIT_MAX = (HEX_MODE != 0) ? 4'hF : 4'h9;

   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] r_shadow;
   logic               r_overflow;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic               r_blink_phase;
   logic [2:0]         r_rgb;

   logic [COUNT_W-1:0] w_count_inc;
   logic               w_carry;
   logic               w_frame_start;
   logic [9:0]         w_rx;
   logic [9:0]         w_ry;
   logic [9:0]         w_cx;
   logic [9:0]         w_cy;
   logic [6:0]         w_digit;
   logic [2:0]         w_col;
   logic               w_inside;
   logic [3:0]         w_code;
   logic [3:0]         w_digit_val;
   logic               w_lz_run;
   logic               w_lz_blank;
   logic [4:0]         w_row_bits;
   logic               w_lit;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b1111110;
         4'h1:    seg = 7'b0110000;
         4'h2:    seg = 7'b1101101;
         4'h3:    seg = 7'b1111001;
         4'h4:    seg = 7'b0110011;
         4'h5:    seg = 7'b1011011;
         4'h6:    seg = 7'b1011111;
         4'h7:    seg = 7'b1110000;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1111011;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b0011111;
         4'hC:    seg = 7'b1001110;
         4'hD:    seg = 7'b0111101;
         4'hE:    seg = 7'b1001111;
         default: seg = 7'b1000111;
      endcase
      if (HEX_MODE == 0 && code > 4'h9) seg = 7'b0000000;
      return seg;
   endfunction

   // Segments {a,b,c,d,e,f,g} folded into a 5-wide row; bit 4 is the leftmost column.
   function automatic logic [4:0] seg_row(input logic [6:0] s, input logic [2:0] row);
      logic a, b, c, d, e, f, g;
      logic [4:0] bits;
      {a, b, c, d, e, f, g} = s;
      case (row)
         3'd0:    bits = {a | f, a, a, a, a | b};
         3'd1:    bits = {f, 3'b000, b};
         3'd2:    bits = {g | e | f, g, g, g, g | b | c};
         3'd3:    bits = {e, 3'b000, c};
         3'd4:    bits = {d | e, d, d, d, d | c};
         default: bits = 5'b00000;
      endcase
      return bits;
   endfunction

   // Ripple-carry increment; w_carry survives the loop only when every digit was at max.
   always_comb begin
      w_count_inc = r_count;
      w_carry     = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (w_carry) begin
            if (r_count[4*i +: 4] == DIGIT_MAX) begin
               w_count_inc[4*i +: 4] = 4'h0;
            end else begin
               w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'h1;
               w_carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (bus.clr) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (bus.inc) begin
         r_count <= w_count_inc;
         if (w_carry) r_overflow <= 1'b1;
      end
   end

   assign w_frame_start = (bus.hpos == 9'd0) && (bus.vpos == 9'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow      <= '0;
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_frame_start) begin
         r_shadow <= r_count;
         if (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
         end
      end
   end

   // Bit 9 of rx/ry acts as the sign: set means left of / above the origin.
   assign w_rx     = {1'b0, bus.hpos} - 10'(X0);
   assign w_ry     = {1'b0, bus.vpos} - 10'(Y0);
   assign w_cx     = w_rx >> SCALE_LOG2;
   assign w_cy     = w_ry >> SCALE_LOG2;
   assign w_digit  = w_cx[9:3];
   assign w_col    = w_cx[2:0];
   assign w_inside = !w_rx[9] && !w_ry[9] && (w_digit < 7'(NUM_DIGITS))
                     && (w_col < 3'd5) && (w_cy < 10'd5);

   // Pick the addressed shadow digit and whether it sits in the run of leading zeros.
   always_comb begin
      w_code      = 4'h0;
      w_lz_blank  = 1'b0;
      w_digit_val = 4'h0;
      w_lz_run    = bus.blank_lz;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         w_digit_val = r_shadow[4*(NUM_DIGITS-1-i) +: 4];
         w_lz_run    = w_lz_run && (w_digit_val == 4'h0) && (i != NUM_DIGITS - 1);
         if (w_digit == 7'(i)) begin
            w_code     = w_digit_val;
            w_lz_blank = w_lz_run;
         end
      end
   end

   assign w_row_bits = seg_row(seg_decode(w_code), w_cy[2:0]);
   assign w_lit      = |(w_row_bits & (5'b10000 >> w_col));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgb <= 3'b000;
      end else begin
         r_rgb <= (bus.display_on && w_inside && w_lit && !w_lz_blank
                   && !(bus.blink_en && r_blink_phase)) ? FG : 3'b000;
      end
   end

   assign bus.count    = r_count;
   assign bus.overflow = r_overflow;
   assign bus.rgb      = r_rgb;
endmodule

// File: doc/seven_segment_counter_display.md
Name: seven_segment_counter_display

Overview:
- Parametrised multi-digit 7-segment renderer with a built-in BCD/hex event counter, for the VGA test designs.
- Keeps a NUM_DIGITS counter driven by inc/clr pulses and latches it into a shadow register at frame start, so the display never tears.
- Draws the digits as scaled 5x5 segment bitmaps at a fixed screen origin, with leading-zero blanking and frame-based blinking.
- Sits beside the video sync generator and feeds the rgb mux.

Parameters:
NUM_DIGITS, 4, number of digits; digit 0 is leftmost and most significant.
X0, 64, left pixel of digit 0.
Y0, 64, top pixel of the digit row.
SCALE_LOG2, 1, each bitmap cell is 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels.
HEX_MODE, 0, 0 = each digit counts 0-9 (BCD); 1 = each digit counts 0-F.
BLINK_FRAMES, 32, frames per blink half-period.
FG, 3'b010, rgb colour of lit cells.

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
display_on  in  1  visible-area flag from the sync generator
hpos  in  9  current pixel column
vpos  in  9  current pixel row
inc  in  1  single-cycle increment pulse
clr  in  1  synchronous clear of count and overflow
blank_lz  in  1  blank leading zeros
blink_en  in  1  enable blinking
count  out  4*NUM_DIGITS  live counter value, digit 0 in the MSBs
overflow  out  1  sticky; set on wrap from the all-max value
rgb  out  3  pixel colour {b,g,r}, registered

Behaviour:
- Reset (asynchronous): count, shadow, overflow, frame counter, blink phase and rgb all go to 0.
- Counter:
  - clr has priority: count <= 0 and overflow <= 0 in the same edge.
  - Otherwise inc adds 1 with ripple carry. Digit max is 9 (BCD) or F (HEX_MODE).
  - Increment from all-max gives all-zero and sets overflow. overflow stays set until clr or reset.
  - Update is visible on count the cycle after the inc edge.
- Frame start is hpos==0 && vpos==0, sampled on a clock edge.
- At frame start:
  - shadow <= count, using the pre-update value if inc occurs in the same cycle.
  - Frame counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
  - Renderer uses only shadow, so mid-frame counter changes are not displayed until the next frame start.
- Geometry, with S = SCALE_LOG2:
  - rx = hpos - X0 and ry = vpos - Y0, computed 10-bit signed; negative means outside.
  - cx = rx>>S, cy = ry>>S.
  - Digit index d = cx>>3 (digit pitch 8 cells), column c = cx[2:0], row = cy.
  - Pixel is inside when rx>=0, ry>=0, d<NUM_DIGITS, c<5 and cy<5.
- Segment decode (bit6..0 = a,b,c,d,e,f,g):
  - Digits 0-9 use the standard table. Example: 2 = 1101101.
  - In HEX_MODE, A-F use the standard A,b,C,d,E,F shapes.
  - Non-decimal codes in BCD mode render blank.
- Bitmap rows (bit 4 = leftmost column):
  - row0 = a across; f at bit 4 and b at bit 0 OR into the corners.
  - row1 = f at bit 4, b at bit 0.
  - row2 = g across; e|f at bit 4; b|c at bit 0.
  - row3 = e at bit 4, c at bit 0.
  - row4 = d across, with e and c in the corners.
  - Column c selects bit 4-c.
- Leading-zero blanking: when blank_lz=1, each zero digit left of the first nonzero digit is blank. The last digit always shows.
- Blink: when blink_en=1 and blink phase=1, all digits are blank. blink_en does not stop the frame counter.
- Output timing:
  - rgb has 1-cycle latency: rgb at edge n+1 reflects hpos/vpos/display_on of cycle n.
  - rgb = FG when display_on, inside and the bitmap bit is lit; otherwise 3'b000.
- Reset mid-frame clears the shadow immediately, so the display shows 0 for the rest of the frame.

Test Plan:
- Reset, then one frame, then sample hpos=64, vpos=64 -> next-cycle rgb=3'b010, since digit 0 is '0' and row 0 is fully lit. Repeat with blank_lz=1 -> rgb=0 at that pixel; pixel (112,64), the last digit, is still lit.
- 1234 inc pulses, then frame start -> count=16'h1234. Digit 1 row 1 (vpos=66): hpos=88 gives rgb=3'b010; hpos=80 gives 3'b000.
- Load 9999, inc -> count=0000, overflow=1. Assert clr and inc in the same cycle -> count=0000, overflow=0.
- inc while vpos=100 mid-frame -> rendered pixels still show the old value until the next hpos=vpos=0, then show the new one.
- BLINK_FRAMES=2, blink_en=1 -> digits visible 2 frames, blank 2 frames, repeating. With display_on=0, rgb=0 everywhere.
- HEX_MODE=1: inc from 000F -> 0010. From FFFF, inc -> 0000 with overflow=1. Digit A renders row 4 as 10001.
